// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with one-cycle logic/arith/shift ops
// and iterative signed multiply/divide behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHRA = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_NEG  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t r_state;
    state_t w_next;

    // Working registers for the iterative ops: r_acc is the upper half
    // (partial product / partial remainder), r_wlo the lower half
    // (multiplier bits / quotient bits), r_opd the fixed operand magnitude.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_wlo;
    logic [WIDTH-1:0] r_opd;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic [SHW:0]     r_cnt;

    logic             r_done;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_dz;

    logic [SHW-1:0]   w_amt;
    logic [SHW-1:0]   w_amt_n;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_sl_lo;
    logic [WIDTH-1:0] w_sl_hi;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_tr;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_amt    = b[SHW-1:0];
    // Rotate-left by k is rotate-right by (WIDTH-k) mod WIDTH.
    assign w_amt_n  = '0 - w_amt;
    assign w_b_zero = (b == '0);
    assign w_mag_a  = a[WIDTH-1] ? ('0 - a) : a;
    assign w_mag_b  = b[WIDTH-1] ? ('0 - b) : b;
    assign w_ror    = WIDTH'({a, a} >> w_amt);
    assign w_rol    = WIDTH'({a, a} >> w_amt_n);

    assign w_mul_sum = {1'b0, r_acc} + (r_wlo[0] ? {1'b0, r_opd} : '0);
    assign w_div_sh  = {r_acc, r_wlo[WIDTH-1]};
    assign w_div_tr  = w_div_sh - {1'b0, r_opd};
    assign w_prod    = {r_acc, r_wlo};
    assign w_prod_s  = r_neg_lo ? ('0 - w_prod) : w_prod;
    assign w_quot    = r_neg_lo ? ('0 - r_wlo) : r_wlo;
    assign w_rem     = r_neg_hi ? ('0 - r_acc) : r_acc;

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;
    assign div_zero  = r_dz;

    // Single-cycle result decode straight from the input operands.
    always_comb begin
        w_sl_lo = '0;
        w_sl_hi = '0;
        case (op)
            OP_OR:   w_sl_lo = a | b;
            OP_AND:  w_sl_lo = a & b;
            OP_NOT:  w_sl_lo = ~a;
            OP_ADD:  w_sl_lo = a + b;
            OP_SUB:  w_sl_lo = a - b;
            OP_SHR:  w_sl_lo = a >> w_amt;
            OP_SHRA: w_sl_lo = $unsigned($signed(a) >>> w_amt);
            OP_SHL:  w_sl_lo = a << w_amt;
            OP_ROR:  w_sl_lo = w_ror;
            OP_ROL:  w_sl_lo = w_rol;
            OP_NEG:  w_sl_lo = '0 - a;
            OP_DIV: begin
                w_sl_lo = '1;
                w_sl_hi = a;
            end
            default: begin
                w_sl_lo = '0;
                w_sl_hi = '0;
            end
        endcase
    end

    // Next-state: only MUL and non-zero DIV leave IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && op == OP_MUL) begin
                    w_next = S_MUL;
                end else if (start && op == OP_DIV && !w_b_zero) begin
                    w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: operand capture, shift-add / restoring iterations, results.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_acc    <= '0;
            r_wlo    <= '0;
            r_opd    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dz  <= (op == OP_DIV) && w_b_zero;
                        r_cnt <= '0;
                        if (op == OP_MUL) begin
                            r_acc    <= '0;
                            r_wlo    <= w_mag_b;
                            r_opd    <= w_mag_a;
                            r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_hi <= 1'b0;
                        end else if (op == OP_DIV && !w_b_zero) begin
                            r_acc    <= '0;
                            r_wlo    <= w_mag_a;
                            r_opd    <= w_mag_b;
                            r_neg_lo <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_hi <= a[WIDTH-1];
                        end else begin
                            r_done   <= 1'b1;
                            r_res_lo <= w_sl_lo;
                            r_res_hi <= w_sl_hi;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == CNT_LAST) begin
                        r_done   <= 1'b1;
                        r_res_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_res_lo <= w_prod_s[WIDTH-1:0];
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_wlo <= {w_mul_sum[0], r_wlo[WIDTH-1:1]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == CNT_LAST) begin
                        r_done   <= 1'b1;
                        r_res_lo <= w_quot;
                        r_res_hi <= w_rem;
                    end else begin
                        r_acc <= w_div_tr[WIDTH] ? w_div_sh[WIDTH-1:0]
                                                 : w_div_tr[WIDTH-1:0];
                        r_wlo <= {r_wlo[WIDTH-2:0], ~w_div_tr[WIDTH]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
